mem_stage: RTL and testbench

// MEM pipeline stage: transmitter side of the in_valid/in_ready handshake into WB.

---
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, SRAM load-data capture/extension,
// valid/ready handoff into WB and a forwarding view for ID.
module mem_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RF_AW  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_pc,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic              ex_res_from_mem,
   input  logic [2:0]        ex_ld_op,
   input  logic              ex_gr_we,
   input  logic [RF_AW-1:0]  ex_dest,
   input  logic [DATA_W-1:0] data_sram_rdata,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_pc,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_rdata,
   output logic              wb_res_from_mem,
   output logic              wb_gr_we,
   output logic [RF_AW-1:0]  wb_dest,
   output logic              fwd_we,
   output logic [RF_AW-1:0]  fwd_dest,
   output logic [DATA_W-1:0] fwd_data
);

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_B  = 3'b001;
   localparam logic [2:0] LD_H  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;

   logic              valid_r;
   logic              first_r;
   logic              hold_vld;
   logic [DATA_W-1:0] hold_r;
   logic [DATA_W-1:0] pc_r;
   logic [DATA_W-1:0] alu_result_r;
   logic              res_from_mem_r;
   logic [2:0]        ld_op_r;
   logic              gr_we_r;
   logic [RF_AW-1:0]  dest_r;

   logic [DATA_W-1:0] raw;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] ext_data;

   // Stage can take new work when empty or when WB drains it this cycle.
   assign ex_ready = ~valid_r | wb_ready;

   // Pipeline register plus first-cycle SRAM data hold across WB stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r        <= 1'b0;
         first_r        <= 1'b0;
         hold_vld       <= 1'b0;
         hold_r         <= '0;
         pc_r           <= '0;
         alu_result_r   <= '0;
         res_from_mem_r <= 1'b0;
         ld_op_r        <= 3'b000;
         gr_we_r        <= 1'b0;
         dest_r         <= '0;
      end else if (ex_ready) begin
         valid_r  <= ex_valid;
         first_r  <= ex_valid;
         hold_vld <= 1'b0;
         if (ex_valid) begin
            pc_r           <= ex_pc;
            alu_result_r   <= ex_alu_result;
            res_from_mem_r <= ex_res_from_mem;
            ld_op_r        <= ex_ld_op;
            gr_we_r        <= ex_gr_we;
            dest_r         <= ex_dest;
         end
      end else begin
         // Stalled: SRAM data is only valid in the first cycle, so latch it.
         first_r <= 1'b0;
         if (first_r && res_from_mem_r) begin
            hold_r   <= data_sram_rdata;
            hold_vld <= 1'b1;
         end
      end
   end

   assign raw = hold_vld ? hold_r : data_sram_rdata;

   // Byte/half select by address and sign/zero extension of load data.
   always_comb begin
      byte_sel = raw[7:0];
      half_sel = raw[15:0];
      ext_data = raw;
      case (alu_result_r[1:0])
         2'd1:    byte_sel = raw[15:8];
         2'd2:    byte_sel = raw[23:16];
         2'd3:    byte_sel = raw[31:24];
         default: byte_sel = raw[7:0];
      endcase
      if (alu_result_r[1]) begin
         half_sel = raw[31:16];
      end
      case (ld_op_r)
         LD_B:    ext_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_BU:   ext_data = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_H:    ext_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_HU:   ext_data = {{(DATA_W-16){1'b0}}, half_sel};
         LD_W:    ext_data = raw;
         default: ext_data = raw;
      endcase
   end

   // Payload to WB.
   assign wb_valid        = valid_r;
   assign wb_pc           = pc_r;
   assign wb_alu_result   = alu_result_r;
   assign wb_rdata        = res_from_mem_r ? ext_data : '0;
   assign wb_res_from_mem = res_from_mem_r;
   assign wb_gr_we        = gr_we_r;
   assign wb_dest         = dest_r;

   // Forwarding view of the in-flight instruction.
   assign fwd_we   = valid_r & gr_we_r & (dest_r != '0);
   assign fwd_dest = dest_r;
   assign fwd_data = res_from_mem_r ? wb_rdata : alu_result_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
module tb_mem_stage;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_alu_result;
   logic        ex_res_from_mem;
   logic [2:0]  ex_ld_op;
   logic        ex_gr_we;
   logic [4:0]  ex_dest;
   logic [31:0] data_sram_rdata;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_pc;
   logic [31:0] wb_alu_result;
   logic [31:0] wb_rdata;
   logic        wb_res_from_mem;
   logic        wb_gr_we;
   logic [4:0]  wb_dest;
   logic        fwd_we;
   logic [4:0]  fwd_dest;
   logic [31:0] fwd_data;

   int total;
   int bad;

   mem_stage #(.DATA_W(32), .RF_AW(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_valid        (ex_valid),
      .ex_ready        (ex_ready),
      .ex_pc           (ex_pc),
      .ex_alu_result   (ex_alu_result),
      .ex_res_from_mem (ex_res_from_mem),
      .ex_ld_op        (ex_ld_op),
      .ex_gr_we        (ex_gr_we),
      .ex_dest         (ex_dest),
      .data_sram_rdata (data_sram_rdata),
      .wb_valid        (wb_valid),
      .wb_ready        (wb_ready),
      .wb_pc           (wb_pc),
      .wb_alu_result   (wb_alu_result),
      .wb_rdata        (wb_rdata),
      .wb_res_from_mem (wb_res_from_mem),
      .wb_gr_we        (wb_gr_we),
      .wb_dest         (wb_dest),
      .fwd_we          (fwd_we),
      .fwd_dest        (fwd_dest),
      .fwd_data        (fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic rfm, input logic [2:0] op, input logic we,
                         input logic [4:0] dest);
      ex_valid        = v;
      ex_pc           = pc;
      ex_alu_result   = alu;
      ex_res_from_mem = rfm;
      ex_ld_op        = op;
      ex_gr_we        = we;
      ex_dest         = dest;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
      total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready got=%0b exp=1", ex_ready); end
      total++; if (fwd_we !== 1'b0) begin bad++; $display("FAIL reset_fwd_we got=%0b exp=0", fwd_we); end
      total++; if (wb_rdata !== 32'h0) begin bad++; $display("FAIL reset_wb_rdata got=%h exp=0", wb_rdata); end
      rst = 1'b0;
   endtask

   task automatic test_load_word();
      wb_ready = 1'b1;
      set_ex(1'b1, 32'h1000, 32'h100, 1'b1, 3'b000, 1'b1, 5'd5);
      tick();
      ex_valid = 1'b0;
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL ldw_wb_valid got=%0b exp=1", wb_valid); end
      total++; if (wb_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ldw_wb_rdata got=%h exp=deadbeef", wb_rdata); end
      total++; if (fwd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ldw_fwd_data got=%h exp=deadbeef", fwd_data); end
      total++; if (fwd_we !== 1'b1 || fwd_dest !== 5'd5) begin bad++; $display("FAIL ldw_fwd got we=%0b dest=%0d exp we=1 dest=5", fwd_we, fwd_dest); end
      total++; if (wb_pc !== 32'h1000) begin bad++; $display("FAIL ldw_wb_pc got=%h exp=1000", wb_pc); end
      tick();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL ldw_drain_valid got=%0b exp=0", wb_valid); end
      total++; if (wb_pc !== 32'h1000) begin bad++; $display("FAIL ldw_payload_kept got=%h exp=1000", wb_pc); end
   endtask

   task automatic test_extension();
      logic [31:0] addr [6];
      logic [2:0]  op   [6];
      logic [31:0] exp  [6];
      addr[0] = 32'h103; op[0] = 3'b001; exp[0] = 32'hFFFFFF80;
      addr[1] = 32'h103; op[1] = 3'b011; exp[1] = 32'h00000080;
      addr[2] = 32'h102; op[2] = 3'b010; exp[2] = 32'hFFFF80FF;
      addr[3] = 32'h102; op[3] = 3'b100; exp[3] = 32'h000080FF;
      addr[4] = 32'h100; op[4] = 3'b001; exp[4] = 32'h00000011;
      addr[5] = 32'h100; op[5] = 3'b101; exp[5] = 32'h80FF0011;
      wb_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_ex(1'b1, 32'h2000 + 32'(i * 4), addr[i], 1'b1, op[i], 1'b1, 5'd8);
         data_sram_rdata = 32'h0;
         tick();
         ex_valid = 1'b0;
         data_sram_rdata = 32'h80FF0011;
         #1;
         total++;
         if (wb_rdata !== exp[i] || wb_valid !== 1'b1) begin
            bad++;
            $display("FAIL ext_%0d got=%h valid=%0b exp=%h valid=1", i, wb_rdata, wb_valid, exp[i]);
         end
      end
      tick();
   endtask

   task automatic test_stall();
      wb_ready = 1'b0;
      set_ex(1'b1, 32'h3000, 32'h100, 1'b1, 3'b000, 1'b1, 5'd6);
      tick();
      data_sram_rdata = 32'hDEADBEEF;
      set_ex(1'b1, 32'h3004, 32'h55, 1'b0, 3'b000, 1'b1, 5'd9);
      #1;
      total++; if (wb_valid !== 1'b1 || ex_ready !== 1'b0) begin bad++; $display("FAIL stall_first got valid=%0b ready=%0b exp valid=1 ready=0", wb_valid, ex_ready); end
      total++; if (wb_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL stall_first_rdata got=%h exp=deadbeef", wb_rdata); end
      for (int i = 0; i < 3; i++) begin
         tick();
         data_sram_rdata = 32'h12345678;
         #1;
         total++;
         if (wb_rdata !== 32'hDEADBEEF || ex_ready !== 1'b0 || wb_dest !== 5'd6 || fwd_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL stall_hold_%0d got rdata=%h ready=%0b dest=%0d fwd=%h exp rdata=deadbeef ready=0 dest=6 fwd=deadbeef",
                     i, wb_rdata, ex_ready, wb_dest, fwd_data);
         end
      end
      wb_ready = 1'b1;
      #1;
      total++; if (ex_ready !== 1'b1 || wb_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL stall_release got ready=%0b rdata=%h exp ready=1 rdata=deadbeef", ex_ready, wb_rdata); end
      tick();
      ex_valid = 1'b0;
      #1;
      total++;
      if (wb_valid !== 1'b1 || wb_dest !== 5'd9 || wb_rdata !== 32'h0 || fwd_data !== 32'h55 || wb_pc !== 32'h3004) begin
         bad++;
         $display("FAIL stall_next got valid=%0b dest=%0d rdata=%h fwd=%h pc=%h exp valid=1 dest=9 rdata=0 fwd=55 pc=3004",
                  wb_valid, wb_dest, wb_rdata, fwd_data, wb_pc);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_ex(1'b1, 32'h4000 + 32'(i), 32'(i * 16), 1'b0, 3'b000, 1'b1, 5'(i));
         tick();
         total++;
         if (wb_valid !== 1'b1 || wb_dest !== 5'(i) || fwd_we !== 1'b1 || fwd_data !== 32'(i * 16) || ex_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_%0d got valid=%0b dest=%0d fwd_we=%0b fwd=%h ready=%0b exp valid=1 dest=%0d fwd_we=1 fwd=%h ready=1",
                     i, wb_valid, wb_dest, fwd_we, fwd_data, ex_ready, i, i * 16);
         end
      end
      set_ex(1'b1, 32'h4010, 32'h77, 1'b0, 3'b000, 1'b1, 5'd0);
      tick();
      total++; if (wb_valid !== 1'b1 || fwd_we !== 1'b0) begin bad++; $display("FAIL b2b_dest0 got valid=%0b fwd_we=%0b exp valid=1 fwd_we=0", wb_valid, fwd_we); end
      ex_valid = 1'b0;
      tick();
      total++; if (wb_valid !== 1'b0 || fwd_we !== 1'b0) begin bad++; $display("FAIL b2b_end got valid=%0b fwd_we=%0b exp 0 0", wb_valid, fwd_we); end
   endtask

   task automatic test_reset_mid_stall();
      wb_ready = 1'b0;
      set_ex(1'b1, 32'h5000, 32'h200, 1'b1, 3'b000, 1'b1, 5'd7);
      tick();
      ex_valid = 1'b0;
      data_sram_rdata = 32'hAAAA5555;
      tick();
      total++; if (wb_valid !== 1'b1 || wb_rdata !== 32'hAAAA5555) begin bad++; $display("FAIL rstall_pre got valid=%0b rdata=%h exp valid=1 rdata=aaaa5555", wb_valid, wb_rdata); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || fwd_we !== 1'b0 || wb_rdata !== 32'h0) begin
         bad++;
         $display("FAIL rstall_post got valid=%0b ready=%0b fwd_we=%0b rdata=%h exp 0 1 0 0", wb_valid, ex_ready, fwd_we, wb_rdata);
      end
      wb_ready = 1'b1;
      tick();
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstall_nodeliver got=%0b exp=0", wb_valid); end
      set_ex(1'b1, 32'h5004, 32'h204, 1'b1, 3'b000, 1'b1, 5'd3);
      tick();
      ex_valid = 1'b0;
      data_sram_rdata = 32'h0BADF00D;
      #1;
      total++; if (wb_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL rstall_fresh got=%h exp=0badf00d", wb_rdata); end
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      wb_ready = 1'b1;
      data_sram_rdata = 32'h0;
      set_ex(1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0, 5'd0);
      test_reset();
      test_load_word();
      test_extension();
      test_stall();
      test_back_to_back();
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
